// File: rtl/ddr3_cmd_tracker.sv
// Passive DDR3 command-bus decoder with per-rank/per-bank state and tRCD/tRP/tRFC checking.
// Optional: define DDR3_CMD_STATS_EN to add 32-bit ACT/RD/WR/REF command counters.
module ddr3_cmd_tracker #(
    parameter int RANKS     = 1,
    parameter int BA_WIDTH  = 3,
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RFC     = 44,
    parameter int TW        = 8,
    localparam int RW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                 ck_p,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic [RANKS-1:0]     cs_n,
    input  logic                 ras_n,
    input  logic                 cas_n,
    input  logic                 we_n,
    input  logic [BA_WIDTH-1:0]  ba,
    input  logic [ROW_WIDTH-1:0] addr,
    output logic                 cmd_valid,
    output logic [3:0]           cmd_code,
    output logic [RW-1:0]        cmd_rank,
    output logic [BA_WIDTH-1:0]  cmd_bank,
    output logic [ROW_WIDTH-1:0] cmd_addr,
    output logic                 cmd_ap,
    output logic                 err_protocol,
    output logic                 err_timing,
    output logic                 err_multi_cs,
    output logic [2:0]           err_sticky
`ifdef DDR3_CMD_STATS_EN
    ,
    output logic [31:0]          stat_act,
    output logic [31:0]          stat_rd,
    output logic [31:0]          stat_wr,
    output logic [31:0]          stat_ref
`endif
);

    localparam int NB = 2 ** BA_WIDTH;
    // Timers load T-1 so they read zero on the T-th edge after the loading command,
    // which is the first edge on which the dependent command is legal.
    localparam logic [TW-1:0] RCD_LD = (T_RCD > 0) ? TW'(T_RCD - 1) : '0;
    localparam logic [TW-1:0] RP_LD  = (T_RP  > 0) ? TW'(T_RP  - 1) : '0;
    localparam logic [TW-1:0] RFC_LD = (T_RFC > 0) ? TW'(T_RFC - 1) : '0;
    localparam logic [ROW_WIDTH-1:0] COL_MASK =
        ROW_WIDTH'((64'd1 << COL_WIDTH) - 64'd1) & ~(ROW_WIDTH'(1) << 10);

    typedef enum logic [3:0] {
        C_NOP = 4'd0, C_ACT = 4'd1, C_RD = 4'd2, C_WR = 4'd3, C_PRE = 4'd4,
        C_PREA = 4'd5, C_REF = 4'd6, C_MRS = 4'd7, C_ZQ = 4'd8
    } cmd_e;

    typedef enum logic { B_IDLE = 1'b0, B_ACTIVE = 1'b1 } bank_st_e;

    bank_st_e             st_q  [RANKS][NB];
    bank_st_e             st_d  [RANKS][NB];
    logic [ROW_WIDTH-1:0] row_q [RANKS][NB];
    logic [ROW_WIDTH-1:0] row_d [RANKS][NB];
    logic [TW-1:0]        tmr_q [RANKS][NB];
    logic [TW-1:0]        tmr_d [RANKS][NB];
    logic [TW-1:0]        rfc_q [RANKS];
    logic [TW-1:0]        rfc_d [RANKS];

    cmd_e                 code;
    logic [RW-1:0]        rk;
    logic                 any_cs;
    logic                 multi;
    int                   n_low;
    logic                 dec_valid;
    logic                 upd;
    logic                 rank_busy;
    logic                 prot_err;
    logic                 tim_err;
    logic [ROW_WIDTH-1:0] out_addr;

    // Pin decode; the lowest selected rank wins when several chip selects are low.
    always_comb begin
        rk     = '0;
        any_cs = 1'b0;
        n_low  = 0;
        for (int i = RANKS - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                rk     = RW'(i);
                any_cs = 1'b1;
                n_low  = n_low + 1;
            end
        end
        multi = (n_low > 1);
        case ({ras_n, cas_n, we_n})
            3'b011:  code = C_ACT;
            3'b101:  code = C_RD;
            3'b100:  code = C_WR;
            3'b010:  code = addr[10] ? C_PREA : C_PRE;
            3'b001:  code = C_REF;
            3'b000:  code = C_MRS;
            3'b110:  code = C_ZQ;
            default: code = C_NOP;
        endcase
    end

    assign dec_valid = cke && any_cs && (code != C_NOP);
    assign upd       = dec_valid && !multi;

    always_comb begin
        rank_busy = 1'b0;
        for (int b = 0; b < NB; b++)
            if (st_q[rk][b] == B_ACTIVE) rank_busy = 1'b1;
    end

    always_comb begin
        prot_err = 1'b0;
        tim_err  = 1'b0;
        if (upd) begin
            case (code)
                C_ACT: begin
                    prot_err = (st_q[rk][ba] == B_ACTIVE);
                    tim_err  = (tmr_q[rk][ba] != '0) || (rfc_q[rk] != '0);
                end
                C_RD, C_WR: begin
                    prot_err = (st_q[rk][ba] == B_IDLE);
                    tim_err  = (st_q[rk][ba] == B_ACTIVE) && (tmr_q[rk][ba] != '0);
                end
                C_REF:   prot_err = rank_busy;
                default: ;
            endcase
        end
    end

    // Bank FSM next state; timing errors still let the command take effect.
    always_comb begin
        for (int r = 0; r < RANKS; r++) begin
            rfc_d[r] = (rfc_q[r] != '0) ? rfc_q[r] - 1'b1 : '0;
            for (int b = 0; b < NB; b++) begin
                st_d[r][b]  = st_q[r][b];
                row_d[r][b] = row_q[r][b];
                tmr_d[r][b] = (tmr_q[r][b] != '0) ? tmr_q[r][b] - 1'b1 : '0;
            end
        end
        if (upd && !prot_err) begin
            case (code)
                C_ACT: begin
                    st_d[rk][ba]  = B_ACTIVE;
                    row_d[rk][ba] = addr;
                    tmr_d[rk][ba] = RCD_LD;
                end
                C_RD, C_WR: begin
                    if (addr[10]) begin
                        st_d[rk][ba]  = B_IDLE;
                        tmr_d[rk][ba] = RP_LD;
                    end
                end
                C_PRE: begin
                    st_d[rk][ba]  = B_IDLE;
                    tmr_d[rk][ba] = RP_LD;
                end
                C_PREA: begin
                    for (int b = 0; b < NB; b++) begin
                        st_d[rk][b]  = B_IDLE;
                        tmr_d[rk][b] = RP_LD;
                    end
                end
                C_REF:   rfc_d[rk] = RFC_LD;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_addr = addr;
        if (code == C_RD || code == C_WR) out_addr = addr & COL_MASK;
    end

    always_ff @(posedge ck_p) begin
        if (!reset_n) begin
            for (int r = 0; r < RANKS; r++) begin
                rfc_q[r] <= '0;
                for (int b = 0; b < NB; b++) begin
                    st_q[r][b]  <= B_IDLE;
                    row_q[r][b] <= '0;
                    tmr_q[r][b] <= '0;
                end
            end
            cmd_valid    <= 1'b0;
            cmd_code     <= '0;
            cmd_rank     <= '0;
            cmd_bank     <= '0;
            cmd_addr     <= '0;
            cmd_ap       <= 1'b0;
            err_protocol <= 1'b0;
            err_timing   <= 1'b0;
            err_multi_cs <= 1'b0;
            err_sticky   <= '0;
        end else begin
            st_q  <= st_d;
            row_q <= row_d;
            tmr_q <= tmr_d;
            rfc_q <= rfc_d;
            cmd_valid    <= dec_valid;
            cmd_code     <= dec_valid ? code : C_NOP;
            cmd_rank     <= dec_valid ? rk : '0;
            cmd_bank     <= dec_valid ? ba : '0;
            cmd_addr     <= dec_valid ? out_addr : '0;
            cmd_ap       <= dec_valid && (code == C_RD || code == C_WR) && addr[10];
            err_protocol <= prot_err;
            err_timing   <= tim_err;
            err_multi_cs <= dec_valid && multi;
            err_sticky   <= err_sticky | {dec_valid && multi, tim_err, prot_err};
        end
    end

`ifdef DDR3_CMD_STATS_EN
    always_ff @(posedge ck_p) begin
        if (!reset_n) begin
            stat_act <= '0;
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_ref <= '0;
        end else if (dec_valid) begin
            if (code == C_ACT) stat_act <= stat_act + 32'd1;
            if (code == C_RD)  stat_rd  <= stat_rd  + 32'd1;
            if (code == C_WR)  stat_wr  <= stat_wr  + 32'd1;
            if (code == C_REF) stat_ref <= stat_ref + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_cmd_tracker.sv
// Bench for ddr3_cmd_tracker: directed command sequence on a two-rank instance, checked
// every cycle against a cycle-stamp model plus literal expectations.
module tb_ddr3_cmd_tracker;
    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_RFC = 44;
    localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010,
                           REF = 3'b001, MRS = 3'b000, ZQ = 3'b110, NOPC = 3'b111;

    logic        ck_p = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b0;
    logic [1:0]  cs_n = 2'b11;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [13:0] addr = '0;
    logic        cmd_valid, cmd_ap, err_protocol, err_timing, err_multi_cs;
    logic [3:0]  cmd_code;
    logic        cmd_rank;
    logic [2:0]  cmd_bank;
    logic [13:0] cmd_addr;
    logic [2:0]  err_sticky;
`ifdef DDR3_CMD_STATS_EN
    logic [31:0] stat_act, stat_rd, stat_wr, stat_ref;
    logic [31:0] m_act, m_rd, m_wr, m_ref;
`endif

    always #5 ck_p = ~ck_p;

    ddr3_cmd_tracker #(.RANKS(2)) u_dut (
        .ck_p(ck_p), .reset_n(reset_n), .cke(cke), .cs_n(cs_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_rank(cmd_rank),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_ap(cmd_ap),
        .err_protocol(err_protocol), .err_timing(err_timing),
        .err_multi_cs(err_multi_cs), .err_sticky(err_sticky)
`ifdef DDR3_CMD_STATS_EN
        , .stat_act(stat_act), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_ref(stat_ref)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [2:0] rcw, input logic a10);
        case (rcw)
            ACT:     return 1;
            RD:      return 2;
            WR:      return 3;
            PRE:     return a10 ? 5 : 4;
            REF:     return 6;
            MRS:     return 7;
            ZQ:      return 8;
            default: return 0;
        endcase
    endfunction

    // Model: each bank remembers the first cycle at which it may take ACT/RD/WR again.
    int   cyc = 0;
    bit   m_open [2][8];
    int   ready  [2][8];
    int   rfc_ready [2];
    bit          e_valid, e_ap, e_prot, e_tim, e_multi, e_rank;
    logic [3:0]  e_code;
    logic [2:0]  e_bank;
    logic [13:0] e_addr;
    logic [2:0]  e_sticky = '0;

    always @(posedge ck_p) begin
        int c;
        int r;
        bit busy;
        cyc++;
        {e_valid, e_ap, e_prot, e_tim, e_multi, e_rank} = '0;
        e_code = '0; e_bank = '0; e_addr = '0;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                rfc_ready[i] = 0;
                for (int j = 0; j < 8; j++) begin m_open[i][j] = 1'b0; ready[i][j] = 0; end
            end
            e_sticky = '0;
`ifdef DDR3_CMD_STATS_EN
            m_act = 0; m_rd = 0; m_wr = 0; m_ref = 0;
`endif
        end else if (cke && cs_n != 2'b11) begin
            c = decode({ras_n, cas_n, we_n}, addr[10]);
            if (c != 0) begin
                r = cs_n[0] ? 1 : 0;
                e_valid = 1'b1;
                e_code  = 4'(c);
                e_rank  = r[0];
                e_bank  = ba;
                e_addr  = (c == 2 || c == 3) ? {4'b0, addr[9:0]} : addr;
                e_ap    = (c == 2 || c == 3) && addr[10];
`ifdef DDR3_CMD_STATS_EN
                if (c == 1) m_act++;
                if (c == 2) m_rd++;
                if (c == 3) m_wr++;
                if (c == 6) m_ref++;
`endif
                if (cs_n == 2'b00) e_multi = 1'b1;
                else begin
                    case (c)
                        1: begin
                            e_tim = (cyc < ready[r][ba]) || (cyc < rfc_ready[r]);
                            if (m_open[r][ba]) e_prot = 1'b1;
                            else begin m_open[r][ba] = 1'b1; ready[r][ba] = cyc + T_RCD; end
                        end
                        2, 3: begin
                            if (!m_open[r][ba]) e_prot = 1'b1;
                            else begin
                                e_tim = cyc < ready[r][ba];
                                if (addr[10]) begin m_open[r][ba] = 1'b0; ready[r][ba] = cyc + T_RP; end
                            end
                        end
                        4: begin m_open[r][ba] = 1'b0; ready[r][ba] = cyc + T_RP; end
                        5: for (int j = 0; j < 8; j++) begin m_open[r][j] = 1'b0; ready[r][j] = cyc + T_RP; end
                        6: begin
                            busy = 1'b0;
                            for (int j = 0; j < 8; j++) busy |= m_open[r][j];
                            if (busy) e_prot = 1'b1;
                            else rfc_ready[r] = cyc + T_RFC;
                        end
                        default: ;
                    endcase
                end
            end
        end
        e_sticky |= {e_multi, e_tim, e_prot};
    end

    always @(negedge ck_p) begin
        if (chk_en) begin
            chk("cmd_valid", cmd_valid, e_valid);
            chk("cmd_code", cmd_code, e_code);
            chk("cmd_rank", cmd_rank, e_rank);
            chk("cmd_bank", cmd_bank, e_bank);
            chk("cmd_addr", cmd_addr, e_addr);
            chk("cmd_ap", cmd_ap, e_ap);
            chk("err_protocol", err_protocol, e_prot);
            chk("err_timing", err_timing, e_tim);
            chk("err_multi_cs", err_multi_cs, e_multi);
            chk("err_sticky", err_sticky, e_sticky);
`ifdef DDR3_CMD_STATS_EN
            chk("stat_act", stat_act, m_act);
            chk("stat_rd", stat_rd, m_rd);
            chk("stat_wr", stat_wr, m_wr);
            chk("stat_ref", stat_ref, m_ref);
`endif
        end
    end

    task automatic drive(input logic [1:0] cs, input logic [2:0] rcw,
                         input logic [2:0] b, input logic [13:0] a);
        @(negedge ck_p);
        cke = 1'b1; cs_n = cs; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
    endtask

    task automatic nop(input int n);
        repeat (n) drive(2'b11, NOPC, 3'd0, 14'd0);
    endtask

    initial begin
        repeat (2) @(negedge ck_p);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_addr", cmd_addr, 0);

        // ACT then RD exactly T_RCD cycles later
        drive(2'b10, ACT, 3'd2, 14'h1A5); nop(1);
        chk("act_code", cmd_code, 1);
        chk("act_addr", cmd_addr, 14'h1A5);
        nop(3);
        drive(2'b10, RD, 3'd2, 14'h040); nop(1);
        chk("rd_code", cmd_code, 2);
        chk("rd_addr", cmd_addr, 14'h040);
        chk("rd_noerr", {err_protocol, err_timing}, 0);

        // tRCD violation, bank stays open
        drive(2'b10, ACT, 3'd1, 14'h022); nop(2);
        drive(2'b10, RD, 3'd1, 14'h008); nop(1);
        chk("trcd_err", err_timing, 1);
        chk("trcd_sticky", err_sticky[1], 1);
        nop(2);
        drive(2'b10, RD, 3'd1, 14'h008); nop(1);
        chk("rd_open_prot", err_protocol, 0);

        // protocol errors
        drive(2'b10, RD, 3'd4, 14'h000); nop(1);
        chk("rd_idle_prot", err_protocol, 1);
        drive(2'b10, ACT, 3'd2, 14'h333); nop(1);
        chk("act_open_prot", err_protocol, 1);

        // WR with auto-precharge, then early ACT, then PRE and legal ACT
        drive(2'b10, ACT, 3'd3, 14'h005); nop(4);
        drive(2'b10, WR, 3'd3, 14'h410); nop(1);
        chk("wr_ap", cmd_ap, 1);
        chk("wr_col", cmd_addr, 14'h010);
        drive(2'b10, ACT, 3'd3, 14'h006); nop(1);
        chk("trp_err", err_timing, 1);
        drive(2'b10, PRE, 3'd3, 14'h000); nop(4);
        drive(2'b10, ACT, 3'd3, 14'h007); nop(1);
        chk("act_after_trp", {err_protocol, err_timing}, 0);

        // multiple chip selects, then tRFC on rank 1
        drive(2'b00, ACT, 3'd5, 14'h007); nop(1);
        chk("multi_cs", err_multi_cs, 1);
        chk("multi_rank", cmd_rank, 0);
        chk("multi_valid", cmd_valid, 1);
        drive(2'b10, RD, 3'd5, 14'h000); nop(1);
        chk("multi_no_open", err_protocol, 1);
        drive(2'b01, REF, 3'd0, 14'h000); nop(1);
        chk("ref_r1", {cmd_rank, err_protocol}, 2'b10);
        nop(8);
        drive(2'b01, ACT, 3'd0, 14'h011); nop(1);
        chk("trfc_err", err_timing, 1);
        drive(2'b10, REF, 3'd0, 14'h000); nop(1);
        chk("ref_busy", err_protocol, 1);
        drive(2'b10, MRS, 3'd1, 14'h123); nop(1);
        chk("mrs_code", cmd_code, 7);
        drive(2'b10, ZQ, 3'd0, 14'h400); nop(1);
        chk("zq_code", cmd_code, 8);

        // cke low ignores the command
        @(negedge ck_p);
        cke = 1'b0; cs_n = 2'b10; {ras_n, cas_n, we_n} = ACT; ba = 3'd6; addr = 14'h009;
        nop(1);
        chk("cke_low", cmd_valid, 0);

        // precharge-all closes every bank of rank 0
        drive(2'b10, PRE, 3'd0, 14'h400); nop(1);
        chk("prea_code", cmd_code, 5);
        drive(2'b10, RD, 3'd1, 14'h000); nop(1);
        chk("prea_closed", err_protocol, 1);

        // reset mid-sequence with a bank open
        drive(2'b10, ACT, 3'd6, 14'h009); nop(6);
        @(negedge ck_p);
        reset_n = 1'b0;
        @(negedge ck_p);
        reset_n = 1'b1;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_sticky", err_sticky, 0);
        drive(2'b10, RD, 3'd6, 14'h000); nop(1);
        chk("rst_bank_idle", err_protocol, 1);
        nop(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
